// File: rtl/pixel_plot_queue_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pixel_plot_queue_pkg : shared screen geometry, pixel entry type and states  |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
package pixel_plot_queue_pkg;

    localparam int SCR_W_DEF = 320;
    localparam int SCR_H_DEF = 240;
    localparam int X_W       = 9;
    localparam int Y_W       = 8;
    localparam int COL_W     = 3;
    localparam int ENTRY_W   = X_W + Y_W + COL_W;

    localparam logic [COL_W-1:0] COLOUR_BLACK = 3'b000;

    typedef struct packed {
        logic [X_W-1:0]   x;
        logic [Y_W-1:0]   y;
        logic [COL_W-1:0] colour;
    } pixel_t;

    typedef enum logic [0:0] {
        S_DRAIN = 1'b0,
        S_CLEAR = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/pixel_plot_queue_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pixel_fifo : synchronous FIFO holding queued {x, y, colour} pixel entries   |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module pixel_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 20
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int           c_aw   = $clog2(DEPTH);
    localparam logic [c_aw:0] c_full = DEPTH[c_aw:0];

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_aw-1:0]  r_wr_ptr;
    logic [c_aw-1:0]  r_rd_ptr;
    logic [c_aw:0]    r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == c_full);
    assign o_empty = (r_count == '0);
    assign o_data  = r_mem[r_rd_ptr];
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/pixel_plot_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pixel_plot_queue : queues pixel writes to a VGA adapter, with blackout sweep |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module pixel_plot_queue
    import pixel_plot_queue_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int SCR_W = SCR_W_DEF,
    parameter int SCR_H = SCR_H_DEF
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             in_valid,
    input  logic [X_W-1:0]   in_x,
    input  logic [Y_W-1:0]   in_y,
    input  logic [COL_W-1:0] in_colour,
    output logic             in_ready,
    input  logic             clear_req,
    output logic             clear_busy,
    output logic [X_W-1:0]   vga_x,
    output logic [Y_W-1:0]   vga_y,
    output logic [COL_W-1:0] vga_colour,
    output logic             vga_plot,
    output logic [7:0]       oob_count
);

    localparam logic [X_W:0]   c_scr_w  = SCR_W[X_W:0];
    localparam logic [Y_W:0]   c_scr_h  = SCR_H[Y_W:0];
    localparam logic [X_W-1:0] c_x_last = X_W'(SCR_W - 1);
    localparam logic [Y_W-1:0] c_y_last = Y_W'(SCR_H - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [X_W-1:0]   r_cx;
    logic [Y_W-1:0]   r_cy;
    logic [X_W-1:0]   r_vga_x;
    logic [Y_W-1:0]   r_vga_y;
    logic [COL_W-1:0] r_vga_colour;
    logic             r_vga_plot;
    logic [7:0]       r_oob_count;
    pixel_t           w_in_pix;
    pixel_t           w_head;
    logic             w_full;
    logic             w_empty;
    logic             w_accept;
    logic             w_oob;
    logic             w_push;
    logic             w_pop;
    logic             w_sweep_last;

    assign in_ready     = !w_full;
    assign w_accept     = in_valid && !w_full;
    assign w_oob        = ({1'b0, in_x} >= c_scr_w) || ({1'b0, in_y} >= c_scr_h);
    assign w_push       = w_accept && !w_oob;
    assign w_in_pix     = '{x: in_x, y: in_y, colour: in_colour};
    assign w_sweep_last = (r_cx == c_x_last) && (r_cy == c_y_last);

    assign vga_x      = r_vga_x;
    assign vga_y      = r_vga_y;
    assign vga_colour = r_vga_colour;
    assign vga_plot   = r_vga_plot;
    assign oob_count  = r_oob_count;

    pixel_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk     (clk),
        .resetn  (resetn),
        .i_push  (w_push),
        .i_data  (w_in_pix),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_DRAIN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A pop in the same cycle as clear_req still completes; the sweep starts after it.
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        clear_busy  = 1'b0;
        case (r_state)
            S_DRAIN: begin
                w_pop = !w_empty;
                if (clear_req) begin
                    w_state_nxt = S_CLEAR;
                end
            end
            S_CLEAR: begin
                clear_busy = 1'b1;
                if (w_sweep_last) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            default: w_state_nxt = S_DRAIN;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_cx <= '0;
            r_cy <= '0;
        end else if (r_state == S_CLEAR) begin
            if (r_cx == c_x_last) begin
                r_cx <= '0;
                r_cy <= (r_cy == c_y_last) ? '0 : r_cy + 1'b1;
            end else begin
                r_cx <= r_cx + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_vga_x      <= '0;
            r_vga_y      <= '0;
            r_vga_colour <= COLOUR_BLACK;
            r_vga_plot   <= 1'b0;
        end else if (r_state == S_CLEAR) begin
            r_vga_x      <= r_cx;
            r_vga_y      <= r_cy;
            r_vga_colour <= COLOUR_BLACK;
            r_vga_plot   <= 1'b1;
        end else if (w_pop) begin
            r_vga_x      <= w_head.x;
            r_vga_y      <= w_head.y;
            r_vga_colour <= w_head.colour;
            r_vga_plot   <= 1'b1;
        end else begin
            r_vga_plot   <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_oob_count <= '0;
        end else if (w_accept && w_oob && (r_oob_count != 8'hFF)) begin
            r_oob_count <= r_oob_count + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pixel_plot_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_pixel_plot_queue : directed bench, full-size and reduced-screen instance |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module tb_pixel_plot_queue;

    localparam int S_W = 20;
    localparam int S_H = 12;

    logic       clk = 1'b0;
    logic       resetn;
    logic       in_valid;
    logic [8:0] in_x;
    logic [7:0] in_y;
    logic [2:0] in_colour;
    logic       clear_req;

    logic       b_in_ready, b_clear_busy, b_vga_plot;
    logic [8:0] b_vga_x;
    logic [7:0] b_vga_y;
    logic [2:0] b_vga_colour;
    logic [7:0] b_oob;
    logic       s_in_ready, s_clear_busy, s_vga_plot;
    logic [8:0] s_vga_x;
    logic [7:0] s_vga_y;
    logic [2:0] s_vga_colour;
    logic [7:0] s_oob;

    int n_checks = 0;
    int n_fail   = 0;
    int busy_cnt;
    int sweep_idx;
    logic [19:0] drained [$];
    logic [19:0] exp_px [9];

    typedef struct {
        logic [8:0] x;
        logic [7:0] y;
        logic [2:0] c;
        logic       exp_plot;
        logic [7:0] exp_oob;
    } vec_t;
    vec_t vecs [7];

    always #5 clk = ~clk;

    pixel_plot_queue u_big (
        .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_x(in_x), .in_y(in_y),
        .in_colour(in_colour), .in_ready(b_in_ready), .clear_req(clear_req),
        .clear_busy(b_clear_busy), .vga_x(b_vga_x), .vga_y(b_vga_y),
        .vga_colour(b_vga_colour), .vga_plot(b_vga_plot), .oob_count(b_oob)
    );

    pixel_plot_queue #(.DEPTH(8), .SCR_W(S_W), .SCR_H(S_H)) u_small (
        .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_x(in_x), .in_y(in_y),
        .in_colour(in_colour), .in_ready(s_in_ready), .clear_req(clear_req),
        .clear_busy(s_clear_busy), .vga_x(s_vga_x), .vga_y(s_vga_y),
        .vga_colour(s_vga_colour), .vga_plot(s_vga_plot), .oob_count(s_oob)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [8:0] x, input logic [7:0] y, input logic [2:0] c);
        in_valid  = v;
        in_x      = x;
        in_y      = y;
        in_colour = c;
    endtask

    task automatic do_reset();
        drive(1'b0, '0, '0, '0);
        clear_req = 1'b0;
        @(negedge clk);
        resetn = 1'b0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        tick();
        busy_cnt  = 0;
        sweep_idx = 0;
        drained.delete();
    endtask

    // Follows the reduced-screen instance: black sweep pixels in raster order, then drained pixels.
    task automatic mon_sweep(input int ncyc);
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            if (s_clear_busy) busy_cnt++;
            if (s_vga_plot) begin
                if (sweep_idx < S_W * S_H) begin
                    check("sweep_px", {s_vga_x, s_vga_y, s_vga_colour},
                          {9'(sweep_idx % S_W), 8'(sweep_idx / S_W), 3'b000});
                    sweep_idx++;
                end else begin
                    drained.push_back({s_vga_x, s_vga_y, s_vga_colour});
                end
            end
        end
    endtask

    task automatic drive_sweep_writes();
        int stalled = 0;
        repeat (3) tick();
        for (int k = 0; k < 9; k++) begin
            int  waited = 0;
            bit  done   = 1'b0;
            drive(1'b1, exp_px[k][19:11], exp_px[k][10:3], exp_px[k][2:0]);
            while (!done) begin
                @(negedge clk);
                if (s_in_ready) begin
                    done = 1'b1;
                    if (k == 8) begin
                        check("ninth_stalled", 32'(stalled > 0), 1);
                        check("ninth_after_sweep", s_clear_busy, 0);
                    end
                end else begin
                    waited++;
                    if (k == 8) stalled++;
                    if (waited > 400) begin
                        check("write_timeout", 0, 1);
                        done = 1'b1;
                    end
                end
                tick();
            end
        end
        drive(1'b0, '0, '0, '0);
    endtask

    task automatic drive_restart_req();
        bit found = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            @(negedge clk);
            if (s_vga_plot && s_vga_x == 9'd5 && s_vga_y == 8'd5) found = 1'b1;
        end
        check("saw_pixel_5_5", found, 1);
        tick();
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
    endtask

    initial begin
        vecs[0] = '{9'd10,  8'd20,  3'b101, 1'b1, 8'd0};
        vecs[1] = '{9'd320, 8'd0,   3'b001, 1'b0, 8'd1};
        vecs[2] = '{9'd0,   8'd240, 3'b010, 1'b0, 8'd2};
        vecs[3] = '{9'd319, 8'd239, 3'b111, 1'b1, 8'd2};
        vecs[4] = '{9'd0,   8'd0,   3'b011, 1'b1, 8'd2};
        vecs[5] = '{9'd511, 8'd255, 3'b110, 1'b0, 8'd3};
        vecs[6] = '{9'd200, 8'd100, 3'b100, 1'b1, 8'd3};
        for (int k = 0; k < 9; k++) begin
            exp_px[k] = {9'(2 + k), 8'(1 + k % 3), 3'((k % 7) + 1)};
        end

        resetn    = 1'b0;
        clear_req = 1'b0;
        drive(1'b0, '0, '0, '0);
        #2;
        check("rst_in_ready", b_in_ready, 1);
        check("rst_plot", b_vga_plot, 0);
        check("rst_busy", b_clear_busy, 0);
        check("rst_oob", b_oob, 0);
        check("rst_vga", {b_vga_x, b_vga_y, b_vga_colour}, 0);
        do_reset();

        // Single accepted writes, in and out of range.
        foreach (vecs[i]) begin
            drive(1'b1, vecs[i].x, vecs[i].y, vecs[i].c);
            @(negedge clk);
            check("vec_ready", b_in_ready, 1);
            tick();
            drive(1'b0, '0, '0, '0);
            @(negedge clk);
            check("vec_plot_early", b_vga_plot, 0);
            tick();
            @(negedge clk);
            check("vec_plot", b_vga_plot, vecs[i].exp_plot);
            if (vecs[i].exp_plot)
                check("vec_pixel", {b_vga_x, b_vga_y, b_vga_colour}, {vecs[i].x, vecs[i].y, vecs[i].c});
            check("vec_oob", b_oob, vecs[i].exp_oob);
            tick();
            @(negedge clk);
            check("vec_plot_after", b_vga_plot, 0);
            tick();
        end

        // Back-to-back stream of 12 pixels, one out per cycle.
        for (int i = 0; i <= 12; i++) begin
            if (i < 12) drive(1'b1, 9'(i * 7 + 3), 8'(i * 5 + 1), 3'(i % 8));
            else        drive(1'b0, '0, '0, '0);
            tick();
            check("stream_ready", b_in_ready, 1);
            check("stream_plot", b_vga_plot, 32'(i >= 1));
            if (i >= 1)
                check("stream_px", {b_vga_x, b_vga_y, b_vga_colour},
                      {9'((i - 1) * 7 + 3), 8'((i - 1) * 5 + 1), 3'((i - 1) % 8)});
        end
        tick();
        check("stream_end", b_vga_plot, 0);

        // Out-of-range saturation.
        do_reset();
        drive(1'b1, 9'd400, 8'd0, 3'd1);
        repeat (300) tick();
        drive(1'b0, '0, '0, '0);
        tick();
        check("oob_saturate", b_oob, 255);
        check("oob_no_plot", b_vga_plot, 0);

        // clear_req in the same cycle as a pop.
        do_reset();
        drive(1'b1, 9'd3, 8'd4, 3'd6);
        tick();
        drive(1'b0, '0, '0, '0);
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        @(negedge clk);
        check("popclr_px", {s_vga_plot, s_vga_x, s_vga_y, s_vga_colour}, {1'b1, 9'd3, 8'd4, 3'd6});
        check("popclr_busy", s_clear_busy, 1);
        tick();
        @(negedge clk);
        check("popclr_sweep0", {s_vga_plot, s_vga_x, s_vga_y, s_vga_colour}, {1'b1, 20'd0});

        // Sweep with writes queued behind it.
        do_reset();
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        fork
            mon_sweep(300);
            drive_sweep_writes();
        join
        check("sweep_busy_cycles", busy_cnt, S_W * S_H);
        check("sweep_pixels", sweep_idx, S_W * S_H);
        check("drain_count", drained.size(), 9);
        for (int k = 0; k < drained.size() && k < 9; k++) check("drain_px", drained[k], exp_px[k]);

        // clear_req during a sweep is ignored.
        do_reset();
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        fork
            mon_sweep(300);
            drive_restart_req();
        join
        check("restart_busy_cycles", busy_cnt, S_W * S_H);
        check("restart_pixels", sweep_idx, S_W * S_H);
        check("restart_no_extra", drained.size(), 0);

        // Asynchronous reset in the middle of a full-size sweep.
        do_reset();
        drive(1'b1, 9'd400, 8'd0, 3'd0);
        tick();
        drive(1'b0, '0, '0, '0);
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        begin
            bit found = 1'b0;
            for (int i = 0; i < 20000 && !found; i++) begin
                @(negedge clk);
                if (b_vga_plot && b_vga_x == 9'd100 && b_vga_y == 8'd50) found = 1'b1;
            end
            check("mid_sweep_reached", found, 1);
        end
        check("mid_oob_before", b_oob, 1);
        #2;
        resetn = 1'b0;
        #1;
        check("async_vga", {b_vga_plot, b_vga_x, b_vga_y, b_vga_colour}, 0);
        check("async_busy", b_clear_busy, 0);
        check("async_oob", b_oob, 0);
        check("async_ready", b_in_ready, 1);
        @(negedge clk);
        resetn = 1'b1;
        drive(1'b1, 9'd10, 8'd20, 3'b101);
        tick();
        drive(1'b0, '0, '0, '0);
        check("post_rst_busy", b_clear_busy, 0);
        check("post_rst_plot_early", b_vga_plot, 0);
        tick();
        check("post_rst_px", {b_vga_plot, b_vga_x, b_vga_y, b_vga_colour}, {1'b1, 9'd10, 8'd20, 3'b101});
        tick();
        check("post_rst_idle", b_vga_plot, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pixel_plot_queue.md
PIXEL_PLOT_QUEUE -- requirements
Module: pixel_plot_queue

Interface
REQ-001 Parameter DEPTH, default 8, FIFO entries (power of two, >=2).
REQ-002 Parameter SCR_W, default 320, screen width in pixels.
REQ-003 Parameter SCR_H, default 240, screen height in pixels.
REQ-004 Port clk  in  1  single clock; all state changes on its rising edge.
REQ-005 Port resetn  in  1  reset, asynchronous and active-low.
REQ-006 Port in_valid  in  1  upstream pixel-write request.
REQ-007 Port in_x  in  9  pixel column.
REQ-008 Port in_y  in  8  pixel row.
REQ-009 Port in_colour  in  3  RGB, 1 bit per channel.
REQ-010 Port in_ready  out  1  queue accepts a write this cycle.
REQ-011 Port clear_req  in  1  request full-screen blackout.
REQ-012 Port clear_busy  out  1  blackout sweep in progress.
REQ-013 Port vga_x  out  9  column to VGA adapter.
REQ-014 Port vga_y  out  8  row to VGA adapter.
REQ-015 Port vga_colour  out  3  colour to VGA adapter.
REQ-016 Port vga_plot  out  1  write strobe to VGA adapter.
REQ-017 Port oob_count  out  8  saturating count of discarded out-of-range writes.

Function
REQ-018 Handshake: write transfers on a rising edge where in_valid && in_ready; in_ready = FIFO not full (combinational), independent of clear_busy.
REQ-019 Full FIFO: in_ready low even if a pop occurs the same cycle; no push-on-full.
REQ-020 Range check at accept: in_x >= SCR_W or in_y >= SCR_H -> handshake completes, entry not stored, oob_count +1, saturating at 255.
REQ-021 FSM states: S_DRAIN, S_CLEAR; reset state S_DRAIN.
REQ-022 S_DRAIN: clear_req high -> S_CLEAR next edge; otherwise stay.
REQ-023 S_DRAIN, FIFO non-empty: pop head each cycle; registered vga_x/y/colour = entry, vga_plot = 1 next cycle; FIFO empty -> vga_plot = 0, vga_x/y/colour hold.
REQ-024 Latency: write accepted at edge N into empty FIFO -> vga_plot high in cycle after edge N+1; throughput one pixel per cycle.
REQ-025 Order: pixels leave in acceptance order; no reordering or merging.
REQ-026 S_CLEAR: sweep counters cx (0..SCR_W-1 inner), cy (0..SCR_H-1 outer); each cycle vga_x = cx, vga_y = cy, vga_colour = 000, vga_plot = 1.
REQ-027 Sweep covers SCR_W*SCR_H cycles (76800 default), starting (0,0), ending (SCR_W-1,SCR_H-1); edge after last pixel -> S_DRAIN, counters cleared.
REQ-028 clear_busy = 1 in every S_CLEAR cycle, 0 in S_DRAIN.
REQ-029 No FIFO pops in S_CLEAR; pushes still accepted until full; queued pixels drain after sweep, so post-clear writes are never erased.
REQ-030 clear_req in S_CLEAR ignored; no restart, no queuing.
REQ-031 clear_req and FIFO pop same S_DRAIN cycle: that pop completes (pixel output next cycle), sweep pixel (0,0) follows one cycle later.
REQ-032 Simultaneous push and pop on non-full FIFO: both occur, occupancy unchanged.

Reset
REQ-033 resetn low, any cycle including mid-sweep: FIFO empty, state S_DRAIN, cx = cy = 0, oob_count = 0, vga_x = 0, vga_y = 0, vga_colour = 000, vga_plot = 0, clear_busy = 0.
REQ-034 in_ready reads 1 while resetn low and after release (FIFO empty).
REQ-035 First accept possible on first rising edge with resetn high.

Structure
REQ-036 Shared package: SCR_W/SCR_H defaults, coordinate widths (9, 8), colour width 3, COLOUR_BLACK = 000.
REQ-037 One sub-module pixel_fifo: synchronous FIFO, 20-bit entries {x, y, colour}, push/pop/full/empty, same clk/resetn.
REQ-038 FSM, sweep counters, range check and output register in pixel_plot_queue.

Verification
REQ-039 Single write (10,20,101) into empty queue -> one vga_plot pulse two cycles after accept, (10,20,101); vga_plot low otherwise.
REQ-040 in_valid held with 12 distinct pixels, no pops blocked -> all 12 out in order, one per cycle, no drops.
REQ-041 clear_req pulse, 9 writes during sweep -> clear_busy high 76800 cycles, every pixel black exactly once, then 9 writes in order; 9th stalls (in_ready low) until drain starts.
REQ-042 Writes (320,0), (0,240), (319,239) -> oob_count = 2, only (319,239) plotted; 300 out-of-range writes -> oob_count = 255.
REQ-043 resetn low at sweep pixel (100,50) -> outputs zero asynchronously; after release clear_busy 0, FIFO empty, new write plotted normally.
REQ-044 clear_req during S_CLEAR at pixel (5,5) -> sweep unaffected, exactly 76800 cycles total.
